// File: rtl/rrf_pkg.sv
// Shared constants and types for the renamed register file and its commit logic.
package rrf_pkg;

  localparam int unsigned RRF_DEPTH = 8;
  localparam int unsigned TAG_W     = $clog2(RRF_DEPTH);
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned PTR_W     = TAG_W + 1;
  localparam int unsigned CNT_W     = TAG_W + 1;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [ADDR_W-1:0] arf_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  typedef struct packed {
    arf_idx_t arf;
    data_t    data;
  } rrf_entry_t;

  typedef struct packed {
    logic     en;
    tag_t     tag;
    arf_idx_t arf;
    data_t    data;
  } commit_t;

endpackage

// File: rtl/rrf_ring_ptr.sv
// Ring pointer with wrap bit; advances by 0, 1 or 2 per cycle, synchronous clear.
module rrf_ring_ptr
  import rrf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [1:0]       inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  ptr_t ptr_q;
  ptr_t ptr_d;

  always_comb begin
    ptr_d = ptr_q + PTR_W'(inc_i);
    if (clr_i) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rrf_commit_unit.sv
// RRF write side: dual tag allocation, tag-addressed result capture and
// in-order dual retirement onto the ARF write ports.
module rrf_commit_unit
  import rrf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_req_A,
  input  logic              alloc_req_B,
  input  logic [ADDR_W-1:0] alloc_arf_A,
  input  logic [ADDR_W-1:0] alloc_arf_B,
  output logic              alloc_gnt_A,
  output logic              alloc_gnt_B,
  output logic [TAG_W-1:0]  alloc_tag_A,
  output logic [TAG_W-1:0]  alloc_tag_B,
  output logic              rrf_full,
  input  logic              cmpl_en_A,
  input  logic              cmpl_en_B,
  input  logic [TAG_W-1:0]  cmpl_tag_A,
  input  logic [TAG_W-1:0]  cmpl_tag_B,
  input  logic [DATA_W-1:0] cmpl_data_A,
  input  logic [DATA_W-1:0] cmpl_data_B,
  output logic              commit_en_A,
  output logic              commit_en_B,
  output logic [ADDR_W-1:0] commit_arf_A,
  output logic [ADDR_W-1:0] commit_arf_B,
  output logic [TAG_W-1:0]  commit_tag_A,
  output logic [TAG_W-1:0]  commit_tag_B,
  output logic [DATA_W-1:0] commit_data_A,
  output logic [DATA_W-1:0] commit_data_B
);

  ptr_t                 head;
  ptr_t                 tail;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     free;
  logic                 full_q, full_d;
  logic [RRF_DEPTH-1:0] busy_q, busy_d;
  logic [RRF_DEPTH-1:0] valid_q, valid_d;
  rrf_entry_t           ent_q [RRF_DEPTH];
  rrf_entry_t           ent_d [RRF_DEPTH];
  commit_t              cmt_a_q, cmt_a_d;
  commit_t              cmt_b_q, cmt_b_d;

  tag_t                 tag_a, tag_b;
  tag_t                 h0, h1;
  logic                 ring_empty;
  logic                 commit_a, commit_b;
  logic [1:0]           n_grant, n_commit;

  // Allocation sees only the registered count; same-cycle retirements free space next cycle.
  assign free        = CNT_W'(RRF_DEPTH) - count_q;
  assign tag_a       = tail[TAG_W-1:0];
  assign tag_b       = alloc_req_A ? tag_a + TAG_W'(1) : tag_a;
  assign alloc_gnt_A = alloc_req_A & ~flush & (free >= CNT_W'(1));
  assign alloc_gnt_B = alloc_req_B & ~flush
                     & (free >= (alloc_req_A ? CNT_W'(2) : CNT_W'(1)))
                     & (alloc_gnt_A | ~alloc_req_A);
  assign alloc_tag_A = tag_a;
  assign alloc_tag_B = tag_b;

  assign h0         = head[TAG_W-1:0];
  assign h1         = h0 + TAG_W'(1);
  assign ring_empty = (head == tail);
  assign commit_a   = ~ring_empty & busy_q[h0] & valid_q[h0];
  assign commit_b   = commit_a & busy_q[h1] & valid_q[h1];

  assign n_grant  = {1'b0, alloc_gnt_A} + {1'b0, alloc_gnt_B};
  assign n_commit = {1'b0, commit_a} + {1'b0, commit_b};

  always_comb begin
    count_d = count_q + CNT_W'(n_grant) - CNT_W'(n_commit);
    if (flush) begin
      count_d = '0;
    end
    full_d = (count_d > CNT_W'(RRF_DEPTH - 2));
  end

  // Entry update order: completion, then retirement clear, then new allocation.
  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    ent_d   = ent_q;
    if (cmpl_en_A && busy_q[cmpl_tag_A]) begin
      valid_d[cmpl_tag_A]    = 1'b1;
      ent_d[cmpl_tag_A].data = cmpl_data_A;
    end
    if (cmpl_en_B && busy_q[cmpl_tag_B]) begin
      valid_d[cmpl_tag_B]    = 1'b1;
      ent_d[cmpl_tag_B].data = cmpl_data_B;
    end
    if (commit_a) begin
      busy_d[h0]  = 1'b0;
      valid_d[h0] = 1'b0;
    end
    if (commit_b) begin
      busy_d[h1]  = 1'b0;
      valid_d[h1] = 1'b0;
    end
    if (alloc_gnt_A) begin
      busy_d[tag_a]    = 1'b1;
      valid_d[tag_a]   = 1'b0;
      ent_d[tag_a].arf = alloc_arf_A;
    end
    if (alloc_gnt_B) begin
      busy_d[tag_b]    = 1'b1;
      valid_d[tag_b]   = 1'b0;
      ent_d[tag_b].arf = alloc_arf_B;
    end
    if (flush) begin
      busy_d  = '0;
      valid_d = '0;
    end
  end

  always_comb begin
    cmt_a_d = '0;
    cmt_b_d = '0;
    if (commit_a && !flush) begin
      cmt_a_d.en   = 1'b1;
      cmt_a_d.tag  = h0;
      cmt_a_d.arf  = ent_q[h0].arf;
      cmt_a_d.data = ent_q[h0].data;
    end
    if (commit_b && !flush) begin
      cmt_b_d.en   = 1'b1;
      cmt_b_d.tag  = h1;
      cmt_b_d.arf  = ent_q[h1].arf;
      cmt_b_d.data = ent_q[h1].data;
    end
  end

  rrf_ring_ptr u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (n_commit),
    .ptr_o (head)
  );

  rrf_ring_ptr u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (n_grant),
    .ptr_o (tail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      busy_q  <= '0;
      valid_q <= '0;
      cmt_a_q <= '0;
      cmt_b_q <= '0;
      for (int unsigned i = 0; i < RRF_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      cmt_a_q <= cmt_a_d;
      cmt_b_q <= cmt_b_d;
      for (int unsigned i = 0; i < RRF_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign rrf_full      = full_q;
  assign commit_en_A   = cmt_a_q.en;
  assign commit_en_B   = cmt_b_q.en;
  assign commit_tag_A  = cmt_a_q.tag;
  assign commit_tag_B  = cmt_b_q.tag;
  assign commit_arf_A  = cmt_a_q.arf;
  assign commit_arf_B  = cmt_b_q.arf;
  assign commit_data_A = cmt_a_q.data;
  assign commit_data_B = cmt_b_q.data;

endmodule

// File: tb/tb_rrf_commit_unit.sv
// Directed bench for rrf_commit_unit: allocation, completion, in-order commit, wrap, flush, reset.
module tb_rrf_commit_unit;
  import rrf_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              alloc_req_A, alloc_req_B;
  logic [ADDR_W-1:0] alloc_arf_A, alloc_arf_B;
  logic              alloc_gnt_A, alloc_gnt_B;
  logic [TAG_W-1:0]  alloc_tag_A, alloc_tag_B;
  logic              rrf_full;
  logic              cmpl_en_A, cmpl_en_B;
  logic [TAG_W-1:0]  cmpl_tag_A, cmpl_tag_B;
  logic [DATA_W-1:0] cmpl_data_A, cmpl_data_B;
  logic              commit_en_A, commit_en_B;
  logic [ADDR_W-1:0] commit_arf_A, commit_arf_B;
  logic [TAG_W-1:0]  commit_tag_A, commit_tag_B;
  logic [DATA_W-1:0] commit_data_A, commit_data_B;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] rf_model [32];

  rrf_commit_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .alloc_req_A   (alloc_req_A),
    .alloc_req_B   (alloc_req_B),
    .alloc_arf_A   (alloc_arf_A),
    .alloc_arf_B   (alloc_arf_B),
    .alloc_gnt_A   (alloc_gnt_A),
    .alloc_gnt_B   (alloc_gnt_B),
    .alloc_tag_A   (alloc_tag_A),
    .alloc_tag_B   (alloc_tag_B),
    .rrf_full      (rrf_full),
    .cmpl_en_A     (cmpl_en_A),
    .cmpl_en_B     (cmpl_en_B),
    .cmpl_tag_A    (cmpl_tag_A),
    .cmpl_tag_B    (cmpl_tag_B),
    .cmpl_data_A   (cmpl_data_A),
    .cmpl_data_B   (cmpl_data_B),
    .commit_en_A   (commit_en_A),
    .commit_en_B   (commit_en_B),
    .commit_arf_A  (commit_arf_A),
    .commit_arf_B  (commit_arf_B),
    .commit_tag_A  (commit_tag_A),
    .commit_tag_B  (commit_tag_B),
    .commit_data_A (commit_data_A),
    .commit_data_B (commit_data_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_req_A = 1'b0;
    alloc_req_B = 1'b0;
    alloc_arf_A = '0;
    alloc_arf_B = '0;
    cmpl_en_A   = 1'b0;
    cmpl_en_B   = 1'b0;
    cmpl_tag_A  = '0;
    cmpl_tag_B  = '0;
    cmpl_data_A = '0;
    cmpl_data_B = '0;
  endtask

  // Inputs change at posedge+1, combinational outputs checked at posedge+3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic ra, input logic [ADDR_W-1:0] aa,
                       input logic rb, input logic [ADDR_W-1:0] ab);
    alloc_req_A = ra;
    alloc_arf_A = aa;
    alloc_req_B = rb;
    alloc_arf_B = ab;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_full", 64'(rrf_full), 64'd0);
    chk("rst_cen_a", 64'(commit_en_A), 64'd0);
    chk("rst_cen_b", 64'(commit_en_B), 64'd0);
    chk("rst_cdata_a", 64'(commit_data_A), 64'd0);
    chk("rst_gnt_a", 64'(alloc_gnt_A), 64'd0);
    rst_n = 1'b1;

    // Fill all eight entries two per cycle
    for (int k = 0; k < 4; k++) begin
      alloc(1'b1, 5'(2 * k + 1), 1'b1, 5'(2 * k + 2));
      settle();
      chk("fill_gnt_a", 64'(alloc_gnt_A), 64'd1);
      chk("fill_tag_a", 64'(alloc_tag_A), 64'(2 * k));
      chk("fill_gnt_b", 64'(alloc_gnt_B), 64'd1);
      chk("fill_tag_b", 64'(alloc_tag_B), 64'(2 * k + 1));
      tick();
      chk("fill_full", 64'(rrf_full), (k == 3) ? 64'd1 : 64'd0);
    end
    settle();
    chk("full_gnt_a", 64'(alloc_gnt_A), 64'd0);
    chk("full_gnt_b", 64'(alloc_gnt_B), 64'd0);
    idle();

    // Out-of-order completion, in-order dual commit
    do_reset();
    alloc(1'b1, 5'd3, 1'b1, 5'd4);
    tick();
    idle();
    cmpl_en_B = 1'b1; cmpl_tag_B = 3'd1; cmpl_data_B = 32'hB;
    tick();
    idle();
    chk("ooo_cen_a0", 64'(commit_en_A), 64'd0);
    tick();
    chk("ooo_cen_a1", 64'(commit_en_A), 64'd0);
    chk("ooo_cen_b1", 64'(commit_en_B), 64'd0);
    cmpl_en_A = 1'b1; cmpl_tag_A = 3'd0; cmpl_data_A = 32'hA;
    tick();
    idle();
    chk("ooo_cen_a2", 64'(commit_en_A), 64'd0);
    tick();
    chk("ooo_cen_a", 64'(commit_en_A), 64'd1);
    chk("ooo_cen_b", 64'(commit_en_B), 64'd1);
    chk("ooo_data_a", 64'(commit_data_A), 64'hA);
    chk("ooo_data_b", 64'(commit_data_B), 64'hB);
    chk("ooo_arf_a", 64'(commit_arf_A), 64'd3);
    chk("ooo_arf_b", 64'(commit_arf_B), 64'd4);
    chk("ooo_tag_a", 64'(commit_tag_A), 64'd0);
    chk("ooo_tag_b", 64'(commit_tag_B), 64'd1);
    tick();
    chk("ooo_done", 64'(commit_en_A), 64'd0);

    // Seven in flight: only one grant, even with a same-cycle commit
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc(1'b1, 5'(k), 1'b1, 5'(k + 10));
      tick();
    end
    alloc(1'b1, 5'd20, 1'b0, 5'd0);
    tick();
    idle();
    chk("c7_full", 64'(rrf_full), 64'd1);
    cmpl_en_A = 1'b1; cmpl_tag_A = 3'd0; cmpl_data_A = 32'h55;
    tick();
    idle();
    alloc(1'b1, 5'd21, 1'b1, 5'd22);
    settle();
    chk("c7_gnt_a", 64'(alloc_gnt_A), 64'd1);
    chk("c7_tag_a", 64'(alloc_tag_A), 64'd7);
    chk("c7_gnt_b", 64'(alloc_gnt_B), 64'd0);
    tick();
    chk("c7_cen_a", 64'(commit_en_A), 64'd1);
    chk("c7_ctag_a", 64'(commit_tag_A), 64'd0);
    chk("c7_cdata_a", 64'(commit_data_A), 64'h55);
    chk("c7_cen_b", 64'(commit_en_B), 64'd0);
    chk("c7_full2", 64'(rrf_full), 64'd1);
    settle();
    chk("c7_gnt_a2", 64'(alloc_gnt_A), 64'd1);
    chk("c7_tag_a2", 64'(alloc_tag_A), 64'd0);
    chk("c7_gnt_b2", 64'(alloc_gnt_B), 64'd0);
    idle();

    // Twelve single-entry round trips across the wrap point
    do_reset();
    for (int i = 0; i < 12; i++) begin
      alloc(1'b1, 5'(i + 1), 1'b0, 5'd0);
      if (i == 5) begin
        cmpl_en_B = 1'b1; cmpl_tag_B = 3'd2; cmpl_data_B = 32'hDEAD;
      end
      settle();
      chk("wrap_gnt", 64'(alloc_gnt_A), 64'd1);
      chk("wrap_tag", 64'(alloc_tag_A), 64'(i % 8));
      tick();
      idle();
      cmpl_en_A = 1'b1; cmpl_tag_A = 3'(i); cmpl_data_A = 32'h100 + 32'(i);
      tick();
      idle();
      chk("wrap_early", 64'(commit_en_A), 64'd0);
      tick();
      chk("wrap_cen", 64'(commit_en_A), 64'd1);
      chk("wrap_ctag", 64'(commit_tag_A), 64'(i % 8));
      chk("wrap_cdata", 64'(commit_data_A), 64'h100 + 64'(i));
      chk("wrap_carf", 64'(commit_arf_A), 64'(i + 1));
      chk("wrap_cen_b", 64'(commit_en_B), 64'd0);
    end

    // Same destination register on both commit ports
    do_reset();
    rf_model[5] = '0;
    alloc(1'b1, 5'd5, 1'b1, 5'd5);
    tick();
    idle();
    cmpl_en_A = 1'b1; cmpl_tag_A = 3'd0; cmpl_data_A = 32'h1;
    cmpl_en_B = 1'b1; cmpl_tag_B = 3'd1; cmpl_data_B = 32'h2;
    tick();
    idle();
    tick();
    chk("same_cen_a", 64'(commit_en_A), 64'd1);
    chk("same_cen_b", 64'(commit_en_B), 64'd1);
    chk("same_arf_b", 64'(commit_arf_B), 64'd5);
    if (commit_en_A) rf_model[commit_arf_A] = commit_data_A;
    if (commit_en_B) rf_model[commit_arf_B] = commit_data_B;
    chk("same_rf5", 64'(rf_model[5]), 64'h2);

    // Flush with five in flight and one ready to retire
    do_reset();
    alloc(1'b1, 5'd1, 1'b1, 5'd2);
    tick();
    alloc(1'b1, 5'd3, 1'b1, 5'd4);
    tick();
    alloc(1'b1, 5'd5, 1'b0, 5'd0);
    tick();
    idle();
    cmpl_en_A = 1'b1; cmpl_tag_A = 3'd0; cmpl_data_A = 32'h7;
    tick();
    idle();
    flush = 1'b1;
    alloc_req_A = 1'b1; alloc_arf_A = 5'd6;
    settle();
    chk("fl_gnt_a", 64'(alloc_gnt_A), 64'd0);
    tick();
    idle();
    chk("fl_cen_a", 64'(commit_en_A), 64'd0);
    chk("fl_full", 64'(rrf_full), 64'd0);
    alloc(1'b1, 5'd9, 1'b1, 5'd10);
    settle();
    chk("fl_gnt_a2", 64'(alloc_gnt_A), 64'd1);
    chk("fl_tag_a2", 64'(alloc_tag_A), 64'd0);
    chk("fl_gnt_b2", 64'(alloc_gnt_B), 64'd1);
    chk("fl_tag_b2", 64'(alloc_tag_B), 64'd1);
    tick();
    idle();
    chk("fl_cen_a2", 64'(commit_en_A), 64'd0);
    cmpl_en_A = 1'b1; cmpl_tag_A = 3'd0; cmpl_data_A = 32'h11;
    cmpl_en_B = 1'b1; cmpl_tag_B = 3'd1; cmpl_data_B = 32'h22;
    tick();
    idle();
    chk("fl_cen_a3", 64'(commit_en_A), 64'd0);
    tick();
    chk("fl_cen_a4", 64'(commit_en_A), 64'd1);
    chk("fl_carf_a4", 64'(commit_arf_A), 64'd9);
    chk("fl_cdata_b4", 64'(commit_data_B), 64'h22);

    // Asynchronous reset in the middle of a cycle
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_cen_a", 64'(commit_en_A), 64'd0);
    chk("ar_cen_b", 64'(commit_en_B), 64'd0);
    chk("ar_cdata_a", 64'(commit_data_A), 64'd0);
    chk("ar_carf_b", 64'(commit_arf_B), 64'd0);
    chk("ar_full", 64'(rrf_full), 64'd0);
    chk("ar_gnt_a", 64'(alloc_gnt_A), 64'd0);
    tick();
    rst_n = 1'b1;
    alloc(1'b1, 5'd1, 1'b0, 5'd0);
    settle();
    chk("ar_tag_a", 64'(alloc_tag_A), 64'd0);
    chk("ar_gnt_a2", 64'(alloc_gnt_A), 64'd1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
